div_16_8_seq: RTL

//   Sequential restoring divider: the inverse of the 8x8 multiplier path.
//   - Divides a 16-bit dividend by an 8-bit divisor.
//   - Returns a 16-bit quotient and an 8-bit remainder, one quotient bit per clock.
//   - Sits between switch/operand inputs and multi_digit_display. The quotient

---
 rtl/div_pkg.sv | 14 +
 rtl/div_16_8_seq_if.sv | 24 ++
 rtl/div_step.sv | 19 +
 rtl/div_16_8_seq.sv | 98 +++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

   localparam int DEF_DIVIDEND_W = 16;
   localparam int DEF_DIVISOR_W  = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

   // Width of a counter that steps through iters values (0 .. iters-1).
   function automatic int cnt_width(input int iters);
      return (iters <= 1) ? 1 : $clog2(iters);
   endfunction

endpackage

// File: rtl/div_16_8_seq_if.sv
// Start/done handshake and operand/result bundle between operand source and divider.
interface div_16_8_seq_if #(
   parameter int DIVIDEND_W = div_pkg::DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = div_pkg::DEF_DIVISOR_W
);
   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int DIVISOR_W = div_pkg::DEF_DIVISOR_W
) (
   input  logic [DIVISOR_W:0]   p_in,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   p_out,
   output logic                 q_bit
);
   logic [DIVISOR_W+1:0] p_sh;
   logic [DIVISOR_W:0]   diff;

   assign p_sh  = {p_in, bit_in};
   assign q_bit = (p_sh >= {2'b00, divisor});
   // When the subtract is taken the result is below the divisor, so the low bits suffice.
   assign diff  = p_sh[DIVISOR_W:0] - {1'b0, divisor};
   assign p_out = q_bit ? diff : p_sh[DIVISOR_W:0];
endmodule

// File: rtl/div_16_8_seq.sv
// Sequential restoring divider: one quotient bit per clock, results held until the next operation.
module div_16_8_seq
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
   input  logic clk,
   input  logic rst_n,
   div_16_8_seq_if.slave bus
);
   localparam int CNT_W = cnt_width(DIVIDEND_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

   div_state_t            state;
   logic [DIVIDEND_W-1:0] sh;
   logic [DIVISOR_W-1:0]  dvsr;
   logic [DIVISOR_W:0]    p;
   logic [DIVISOR_W:0]    p_nxt;
   logic                  q_bit;
   logic [CNT_W-1:0]      cnt;
   logic                  dz;
   logic                  busy_r;
   logic                  done_r;
   logic [DIVIDEND_W-1:0] quotient_r;
   logic [DIVISOR_W-1:0]  remainder_r;
   logic                  div_by_zero_r;

   div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .p_in    (p),
      .bit_in  (sh[DIVIDEND_W-1]),
      .divisor (dvsr),
      .p_out   (p_nxt),
      .q_bit   (q_bit)
   );

   // The dividend shifts out of sh's MSB while quotient bits shift in at the LSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         sh            <= '0;
         dvsr          <= '0;
         p             <= '0;
         cnt           <= '0;
         dz            <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         quotient_r    <= '0;
         remainder_r   <= '0;
         div_by_zero_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_r <= 1'b1;
                  if (bus.divisor != '0) begin
                     sh    <= bus.dividend;
                     dvsr  <= bus.divisor;
                     p     <= '0;
                     cnt   <= '0;
                     dz    <= 1'b0;
                     state <= RUN;
                  end else begin
                     // Divide by zero skips the iterations and reports a saturated quotient.
                     sh    <= '1;
                     dvsr  <= '0;
                     p     <= {1'b0, bus.dividend[DIVISOR_W-1:0]};
                     dz    <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               sh  <= {sh[DIVIDEND_W-2:0], q_bit};
               p   <= p_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= DONE;
            end
            DONE: begin
               done_r        <= 1'b1;
               busy_r        <= 1'b0;
               quotient_r    <= sh;
               remainder_r   <= p[DIVISOR_W-1:0];
               div_by_zero_r <= dz;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.div_by_zero = div_by_zero_r;
endmodule
